axis_crd_tx: RTL and testbench
==============================

// Module: axis_crd_tx
// PURPOSE
//   Credit-based link transmitter; the sending end of the credit link whose receiving end is a credit skid buffer.
//   Accepts words on an AXI-Stream slave port and forwards them on a valid-only link (no ready).
//   Forwards a word only while it holds a credit; the far receiver returns one credit per word it drains.
//   Sits between a local AXIS producer and the registered/retimed link to the remote buffer.
// PARAMETERS
//   n        5              payload width in bytes
//   nb       n*8            payload width in bits
//   CREDITS  4              initial credits = receiver buffer depth, >=1
//   LAT      1              link register stages from accept to lnk_valid, >=1
//   CW       $clog2(CREDITS+1)  credit counter width (derived, not overridden)
// PORTS
//   aclk        in   1    clock, all logic on posedge
//   areset      in   1    reset; synchronous, active-high
//   in_tdata    in   nb   AXIS payload
//   in_tvalid   in   1    AXIS valid
//   in_tready   out  1    AXIS ready; high iff credit available and not in reset
//   lnk_data    out  nb   link payload; valid only with lnk_valid
//   lnk_valid   out  1    one-cycle pulse per forwarded word
//   lnk_credit  in   1    one-cycle pulse = one credit returned by receiver
//   crd_level   out  CW   credits currently held
//   crd_err     out  1    sticky: credit returned while counter already at CREDITS
//   idle        out  1    crd_level==CREDITS and no word in the link pipe
// BEHAVIOUR
//   - Reset (areset=1 at posedge): crd_level<=CREDITS, every pipe valid<=0, crd_err<=0.
//     in_tready=0 combinationally while areset=1. lnk_data is don't-care.
//   - Reset mid-operation: in-flight words are dropped. The receiver must be reset in the same cycle.
//   - in_tready = ~areset & (crd_level!=0). It never depends on in_tvalid.
//   - Accept = in_tvalid & in_tready. The word enters pipe stage 0 on that edge.
//   - Latency: lnk_valid rises exactly LAT cycles after the accepting edge, with lnk_data = accepted word.
//   - Throughput: one word per cycle while credits remain. Order is preserved, with no gaps inserted by the pipe.
//   - Credit counter update per edge, keyed on {accept, lnk_credit}:
//       10 -> -1
//       01 -> +1
//       11 -> unchanged
//       00 -> unchanged
//   - Boundaries:
//     * crd_level==0: in_tready=0, no accept. A lnk_credit that cycle sets level to 1 and ready returns next cycle.
//     * Overflow (01 at level CREDITS): counter saturates at CREDITS and crd_err<=1.
//       crd_err clears only on reset.
//     * Underflow is impossible by construction; an assertion checks accept implies crd_level!=0.
//     * A credit in the same cycle as the accept of the last credit (11 at level 1): level stays 1, ready stays high.
//   - No FSM beyond the counter; the pipe is a LAT-deep valid/data shift register with no back-pressure.
//   - idle is combinational from the registered counter and the pipe valids.
// STRUCTURE
//   - Shared package skid_crd_pkg:
//     * function crd_width(depth) returning $clog2(depth+1)
//     * localparam default CREDITS=4, shared with the receiver so both ends agree on buffer depth
//   - Sub-module crd_tx_pipe (params nb, LAT):
//     * inputs: aclk, areset, valid/data in
//     * outputs: valid/data out
//     * behaviour: only valid bits are reset; data regs are not reset
//   - Top holds the counter, the crd_err flag, ready/idle logic and assertions.
// TESTING (CREDITS=4, LAT=1 unless stated)
//   1 Reset 3 cycles then release -> crd_level=4, in_tready=1, lnk_valid=0, idle=1.
//     During reset in_tready=0.
//   2 Stream 0x01..0x06 with in_tvalid held, no credits -> 4 accepts, then in_tready=0.
//     lnk_valid shows 0x01..0x04 one cycle after each accept; crd_level=0.
//   3 From test 2, pulse lnk_credit once -> next cycle crd_level=1, in_tready=1, 0x05 accepted.
//     0x05 appears on lnk_data the cycle after.
//   4 At crd_level=2, accept and lnk_credit in the same cycle -> crd_level stays 2.
//     lnk_valid with that word 1 cycle later.
//   5 At crd_level=4, pulse lnk_credit -> crd_level stays 4, crd_err=1 and remains 1 until areset.
//   6 LAT=3, reset asserted with 2 words in pipe -> no lnk_valid after reset edge, crd_level=4.
//     Plus a scoreboard random run against a model receiver with random credit return delay: no loss, no reorder.

Source files
------------

// File: rtl/skid_crd_pkg.sv
// Definitions shared by both ends of the credit link (transmitter and credit skid buffer).
// CREDITS_DEFAULT must equal the receiver's buffer depth.
package skid_crd_pkg;

  localparam int CREDITS_DEFAULT = 4;

  function automatic int crd_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/crd_tx_pipe.sv
// Fixed-latency valid/data shift register between the credit gate and the link.
// Only the valid bits are reset, so a reset drops every word still in flight.
module crd_tx_pipe #(
  parameter int nb  = 40,
  parameter int LAT = 1
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          vld_i,
  input  logic [nb-1:0] dat_i,
  output logic          vld_o,
  output logic [nb-1:0] dat_o,
  output logic          busy_o
);

  logic [LAT-1:0] vld_q;
  logic [nb-1:0]  dat_q [LAT];

  always_ff @(posedge aclk) begin
    if (areset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge aclk) begin
    dat_q[0] <= dat_i;
    for (int i = 1; i < LAT; i++) dat_q[i] <= dat_q[i-1];
  end

  assign vld_o  = vld_q[LAT-1];
  assign dat_o  = dat_q[LAT-1];
  assign busy_o = |vld_q;

endmodule

// File: rtl/axis_crd_tx.sv
// Credit-gated AXI-Stream to valid-only link transmitter.
// Words are accepted only while a credit is held; the remote buffer returns one credit per drained word.
module axis_crd_tx
  import skid_crd_pkg::*;
#(
  parameter int n       = 5,
  parameter int nb      = n * 8,
  parameter int CREDITS = CREDITS_DEFAULT,
  parameter int LAT     = 1,
  localparam int CW     = crd_width(CREDITS)
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic [nb-1:0] in_tdata,
  input  logic          in_tvalid,
  output logic          in_tready,
  output logic [nb-1:0] lnk_data,
  output logic          lnk_valid,
  input  logic          lnk_credit,
  output logic [CW-1:0] crd_level,
  output logic          crd_err,
  output logic          idle
);

  localparam logic [CW-1:0] CRD_MAX = CW'(CREDITS);

  logic [CW-1:0] crd_q, crd_d;
  logic          err_q, err_d;
  logic          accept;
  logic          pipe_busy;

  assign in_tready = ~areset & (crd_q != '0);
  assign accept    = in_tvalid & in_tready;

  // A simultaneous accept and credit return cancel out, so ready never drops at level 1.
  always_comb begin
    crd_d = crd_q;
    err_d = err_q;
    case ({accept, lnk_credit})
      2'b10: crd_d = crd_q - CW'(1);
      2'b01: begin
        if (crd_q == CRD_MAX) err_d = 1'b1;
        else                  crd_d = crd_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      crd_q <= CRD_MAX;
      err_q <= 1'b0;
    end else begin
      crd_q <= crd_d;
      err_q <= err_d;
    end
  end

  crd_tx_pipe #(
    .nb (nb),
    .LAT(LAT)
  ) u_pipe (
    .aclk  (aclk),
    .areset(areset),
    .vld_i (accept),
    .dat_i (in_tdata),
    .vld_o (lnk_valid),
    .dat_o (lnk_data),
    .busy_o(pipe_busy)
  );

  assign crd_level = crd_q;
  assign crd_err   = err_q;
  assign idle      = (crd_q == CRD_MAX) & ~pipe_busy;

  a_no_underflow: assert property (@(posedge aclk) disable iff (areset) accept |-> (crd_q != '0));

endmodule

// File: tb/tb_axis_crd_tx.sv
// Directed boundary checks on a LAT=1 transmitter and a randomized scoreboard run on a LAT=3 one.
module tb_axis_crd_tx;
  import skid_crd_pkg::*;

  localparam int NB   = 40;
  localparam int CR   = 4;
  localparam int CW   = crd_width(CR);
  localparam int LAT3 = 3;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic          rst1, tv1, tr1, lv1, lc1, ce1, id1;
  logic [NB-1:0] td1, ld1;
  logic [CW-1:0] cl1;
  logic          rst3, tv3, tr3, lv3, lc3, ce3, id3;
  logic [NB-1:0] td3, ld3;
  logic [CW-1:0] cl3;

  axis_crd_tx #(.n(5), .CREDITS(CR), .LAT(1)) dut (
    .aclk(aclk), .areset(rst1), .in_tdata(td1), .in_tvalid(tv1), .in_tready(tr1),
    .lnk_data(ld1), .lnk_valid(lv1), .lnk_credit(lc1), .crd_level(cl1),
    .crd_err(ce1), .idle(id1)
  );

  axis_crd_tx #(.n(5), .CREDITS(CR), .LAT(LAT3)) dut3 (
    .aclk(aclk), .areset(rst3), .in_tdata(td3), .in_tvalid(tv3), .in_tready(tr3),
    .lnk_data(ld3), .lnk_valid(lv3), .lnk_credit(lc3), .crd_level(cl3),
    .crd_err(ce3), .idle(id3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    logic [NB-1:0] last;
    bit            last_v;
    int            w;
    int            mcred;
    bit            acc, exp_v;
    int            idx;
    logic [NB-1:0] exp_q[$];
    int            due_q[$];
    int            ret_q[$];

    rst1 = 1'b1; tv1 = 1'b0; lc1 = 1'b0; td1 = '0;
    rst3 = 1'b1; tv3 = 1'b0; lc3 = 1'b0; td3 = '0;

    // 1: reset
    repeat (3) begin
      @(negedge aclk);
      chk("rst_tready", tr1, 0);
      nxt();
    end
    rst1 = 1'b0;
    @(negedge aclk);
    chk("post_rst_level", cl1, CR);
    chk("post_rst_ready", tr1, 1);
    chk("post_rst_lv", lv1, 0);
    chk("post_rst_idle", id1, 1);
    chk("post_rst_err", ce1, 0);
    nxt();

    // 2: stream until credits run out
    tv1 = 1'b1; w = 1; last_v = 1'b0; last = '0;
    for (int c = 0; c < 8; c++) begin
      td1 = NB'(w);
      @(negedge aclk);
      chk("t2_lv", lv1, last_v);
      if (last_v) chk("t2_ld", ld1, last);
      chk("t2_ready", tr1, (c < 4));
      last_v = (c < 4);
      last   = NB'(w);
      if (c < 4) w++;
      nxt();
    end
    @(negedge aclk);
    chk("t2_level0", cl1, 0);
    chk("t2_ready0", tr1, 0);
    chk("t2_idle0", id1, 0);
    nxt();

    // 3: one credit back lets word 5 through
    lc1 = 1'b1;
    @(negedge aclk);
    chk("t3_ready_before", tr1, 0);
    nxt();
    lc1 = 1'b0;
    @(negedge aclk);
    chk("t3_level1", cl1, 1);
    chk("t3_ready1", tr1, 1);
    nxt();
    tv1 = 1'b0;
    @(negedge aclk);
    chk("t3_lv", lv1, 1);
    chk("t3_ld", ld1, 5);
    chk("t3_level0", cl1, 0);
    nxt();

    // 4: accept and credit together at level 2
    lc1 = 1'b1;
    nxt();
    nxt();
    lc1 = 1'b0;
    @(negedge aclk);
    chk("t4_level2", cl1, 2);
    nxt();
    tv1 = 1'b1; td1 = NB'('h77); lc1 = 1'b1;
    @(negedge aclk);
    chk("t4_ready", tr1, 1);
    nxt();
    tv1 = 1'b0; lc1 = 1'b0;
    @(negedge aclk);
    chk("t4_level_same", cl1, 2);
    chk("t4_lv", lv1, 1);
    chk("t4_ld", ld1, 'h77);
    nxt();

    // 5: overflow at full credits
    lc1 = 1'b1;
    nxt();
    nxt();
    lc1 = 1'b0;
    @(negedge aclk);
    chk("t5_level_full", cl1, CR);
    chk("t5_err_clear", ce1, 0);
    chk("t5_idle", id1, 1);
    nxt();
    lc1 = 1'b1;
    nxt();
    lc1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      chk("t5_level_sat", cl1, CR);
      chk("t5_err_sticky", ce1, 1);
      nxt();
    end
    rst1 = 1'b1;
    @(negedge aclk);
    chk("t5_rst_ready", tr1, 0);
    chk("t5_err_before_edge", ce1, 1);
    nxt();
    rst1 = 1'b0;
    @(negedge aclk);
    chk("t5_err_cleared", ce1, 0);
    chk("t5_level_rst", cl1, CR);
    nxt();

    // 6: LAT=3, reset with two words in flight
    rst3 = 1'b0;
    tv3 = 1'b1; td3 = NB'('hA1);
    @(negedge aclk);
    chk("t6_ready", tr3, 1);
    nxt();
    td3 = NB'('hA2);
    @(negedge aclk);
    chk("t6_level3", cl3, 3);
    nxt();
    tv3 = 1'b0; rst3 = 1'b1;
    @(negedge aclk);
    chk("t6_rst_ready", tr3, 0);
    chk("t6_rst_lv", lv3, 0);
    nxt();
    rst3 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      chk("t6_no_lv", lv3, 0);
      chk("t6_level", cl3, CR);
      nxt();
    end
    @(negedge aclk);
    chk("t6_idle", id3, 1);
    nxt();

    // Random scoreboard run on LAT=3 against a model receiver
    mcred = CR;
    for (int k = 0; k < 3300; k++) begin
      tv3 = (k < 3000) && ($urandom_range(0, 3) != 0);
      td3 = {8'($urandom), 32'($urandom)};
      idx = -1;
      for (int i = 0; i < ret_q.size(); i++)
        if (idx < 0 && ret_q[i] <= k) idx = i;
      if (idx >= 0) begin
        ret_q.delete(idx);
        lc3 = 1'b1;
      end else begin
        lc3 = 1'b0;
      end
      @(negedge aclk);
      chk("rnd_ready", tr3, (mcred > 0));
      chk("rnd_level", cl3, mcred);
      exp_v = (due_q.size() > 0) && (due_q[0] == k);
      chk("rnd_lv", lv3, exp_v);
      if (exp_v) begin
        chk("rnd_ld", ld3, exp_q[0]);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
        ret_q.push_back(k + 1 + int'($urandom_range(0, 6)));
      end
      acc = tv3 && (mcred > 0);
      if (acc) begin
        exp_q.push_back(td3);
        due_q.push_back(k + LAT3);
      end
      mcred = mcred - int'(acc) + int'(lc3);
      if (mcred > CR) mcred = CR;
      nxt();
    end
    tv3 = 1'b0; lc3 = 1'b0;
    @(negedge aclk);
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_credits_back", ret_q.size(), 0);
    chk("rnd_end_level", cl3, CR);
    chk("rnd_end_idle", id3, 1);
    chk("rnd_end_err", ce3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
